// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and control decode helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} dmem_state_t;

  // Access size in bytes (1, 2 or 4); only meaningful for legal controls.
  function automatic logic [2:0] size_of(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic ctrl_legal(input logic we, input logic [2:0] ctrl);
    logic store_ok;
    store_ok = (ctrl == CTRL_B) || (ctrl == CTRL_H) || (ctrl == CTRL_W);
    if (we) ctrl_legal = store_ok;
    else    ctrl_legal = store_ok || (ctrl == CTRL_BU) || (ctrl == CTRL_HU);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word array with per-byte write enables and a registered read port.
module dmem_bank #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_WIDTH = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [3:0]           we,
  input  logic [IDX_WIDTH-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/datamem_responder.sv
// Load/store responder: serialises one request at a time, splits misaligned accesses
// across two words, and returns extended load data through a held response.
module datamem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_ctrl,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_WIDTH = $clog2(MEM_WORDS);

  dmem_state_t          state_reg, state_next;
  logic                 we_reg;
  logic [2:0]           ctrl_reg;
  logic [1:0]           off_reg;
  logic [IDX_WIDTH-1:0] idx0_reg;
  logic [31:0]          wdata_reg;
  logic                 err_reg;
  logic                 split_reg;
  logic [31:0]          word0_reg;

  logic                 accept;
  logic                 req_legal;
  logic                 req_split;
  logic [2:0]           req_size;
  logic                 addr_unused;

  logic [7:0]           lane_mask;
  logic [63:0]          store_data;
  logic [63:0]          load_window;
  logic [31:0]          word0;
  logic [31:0]          load_data;

  logic                 bank_en;
  logic [3:0]           bank_we;
  logic [IDX_WIDTH-1:0] bank_addr;
  logic [31:0]          bank_wdata;
  logic [31:0]          bank_rdata;

  assign accept      = req_valid && req_ready;
  assign req_legal   = ctrl_legal(req_we, req_ctrl);
  assign req_size    = size_of(req_ctrl);
  assign req_split   = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
  assign addr_unused = ^req_addr[ADDR_WIDTH-1:IDX_WIDTH+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      ctrl_reg  <= 3'b000;
      off_reg   <= 2'b00;
      idx0_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      split_reg <= 1'b0;
      word0_reg <= '0;
    end else begin
      if (accept) begin
        we_reg    <= req_we;
        ctrl_reg  <= req_ctrl;
        off_reg   <= req_addr[1:0];
        idx0_reg  <= req_addr[IDX_WIDTH+1:2];
        wdata_reg <= req_wdata[31:0];
        err_reg   <= !req_legal;
        split_reg <= req_legal && req_split;
      end
      // The first word's read data would be overwritten by the second access.
      if (state_reg == ACC1) word0_reg <= bank_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = req_legal ? ACC0 : RESP;
      ACC0: state_next = split_reg ? ACC1 : RESP;
      ACC1: state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lanes of the 8-byte window {word1, word0} touched by this access.
  assign lane_mask  = ((8'd1 << size_of(ctrl_reg)) - 8'd1) << off_reg;
  assign store_data = {32'd0, wdata_reg} << {off_reg, 3'b000};

  assign word0       = split_reg ? word0_reg : bank_rdata;
  assign load_window = {bank_rdata, word0} >> {off_reg, 3'b000};

  always_comb begin
    load_data = load_window[31:0];
    case (ctrl_reg)
      CTRL_B:  load_data = {{24{load_window[7]}}, load_window[7:0]};
      CTRL_H:  load_data = {{16{load_window[15]}}, load_window[15:0]};
      CTRL_BU: load_data = {24'd0, load_window[7:0]};
      CTRL_HU: load_data = {16'd0, load_window[15:0]};
      default: load_data = load_window[31:0];
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    bank_en    = 1'b0;
    bank_we    = 4'b0000;
    bank_addr  = idx0_reg;
    bank_wdata = store_data[31:0];
    case (state_reg)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        bank_en = 1'b1;
        if (we_reg) bank_we = lane_mask[3:0];
      end
      ACC1: begin
        bank_en    = 1'b1;
        bank_addr  = idx0_reg + 1'b1;
        bank_wdata = store_data[63:32];
        if (we_reg) bank_we = lane_mask[7:4];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        if (!we_reg && !err_reg) resp_rdata = load_data;
      end
      default: ;
    endcase
  end

  dmem_bank #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_datamem_responder.sv
// Scoreboard bench for datamem_responder: byte-array reference model, directed and random traffic.
module tb_datamem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_ctrl = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  datamem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_WORDS  (1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_ctrl   (req_ctrl),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_model [4096];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         rr_mode = 0;
  int         last_hs_edge = -1;
  bit         seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: memory is a flat little-endian byte array, addresses wrap at 4 KiB.
  function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                        input logic [2:0] ctrl, input logic [31:0] wdata);
    exp_t        r;
    bit          legal;
    int          size;
    int          base;
    logic [31:0] v;
    legal = we ? (ctrl == 3'd0 || ctrl == 3'd1 || ctrl == 3'd2)
               : (ctrl == 3'd0 || ctrl == 3'd1 || ctrl == 3'd2 || ctrl == 3'd4 || ctrl == 3'd5);
    r.rdata = '0;
    r.err = !legal;
    r.acc_edge = 0;
    r.lat = 1;
    if (!legal) return r;
    size = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    base = int'(addr % 32'd4096);
    r.lat = ((base % 4) + size > 4) ? 3 : 2;
    v = '0;
    for (int k = 0; k < size; k++) begin
      if (we) mem_model[(base + k) % 4096] = wdata[8*k +: 8];
      else    v[8*k +: 8] = mem_model[(base + k) % 4096];
    end
    if (!we) begin
      if (ctrl == 3'd0 && v[7])  v[31:8]  = '1;
      if (ctrl == 3'd1 && v[15]) v[31:16] = '1;
      r.rdata = v;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rr_mode)
      1:       resp_ready = 1'b1;
      2:       resp_ready = 1'b0;
      default: resp_ready = ($urandom % 3) != 0;
    endcase
  end

  // Monitor: compare every cycle a response is presented, pop on handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=valid required=idle (cycle %0d)", cyc);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc - exp_q[0].acc_edge + 1), 32'(exp_q[0].lat));
        end
        check("rdata", resp_rdata, exp_q[0].rdata);
        check("err", 32'(resp_err), 32'(exp_q[0].err));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (resp_ready) begin
          $display("resp rdata=0x%08h err=%0d lat=%0d", resp_rdata, resp_err, exp_q[0].lat);
          void'(exp_q.pop_front());
          seen = 1'b0;
          last_hs_edge = cyc + 1;
        end
      end
    end
  end

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [2:0] ctrl, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_ctrl  = ctrl;
    req_wdata = wdata;
  endtask

  task automatic wait_accept(output int edge_n);
    int n;
    n = 0;
    edge_n = -1;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        edge_n = cyc + 1;
        return;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=req_ready_low required=accept (cycle %0d)", cyc);
        return;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [2:0] ctrl, input logic [31:0] wdata);
    exp_t e;
    int   edge_n;
    e = model_access(we, addr, ctrl, wdata);
    drive_req(we, addr, ctrl, wdata);
    wait_accept(edge_n);
    e.acc_edge = edge_n;
    if (edge_n >= 0) begin
      exp_q.push_back(e);
      $display("req we=%0d addr=0x%08h ctrl=%03b wdata=0x%08h exp=0x%08h err=%0d",
               we, addr, ctrl, wdata, e.rdata, e.err);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        exp_q.delete();
        seen = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  ctrl_tab [10];
    logic [31:0] hi;
    logic [9:0]  widx;
    logic [1:0]  off;
    logic [2:0]  c;
    logic        we;
    int          edge_n;
    int          n;
    exp_t        e;

    ctrl_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);

    // Known contents for every word the loads below can touch.
    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w * 4), 3'd2, $urandom);
    for (int w = 1016; w < 1024; w++) issue(1'b1, 32'(w * 4), 3'd2, $urandom);

    // Sign and zero extension.
    issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue(1'b0, 32'h13, 3'd0, 32'h0);
    issue(1'b0, 32'h13, 3'd4, 32'h0);
    issue(1'b0, 32'h12, 3'd1, 32'h0);
    issue(1'b0, 32'h12, 3'd5, 32'h0);

    // Misaligned half-word across a word boundary.
    issue(1'b1, 32'h1C, 3'd2, 32'h0);
    issue(1'b1, 32'h20, 3'd2, 32'h0);
    issue(1'b1, 32'h1F, 3'd1, 32'h1234ABCD);
    issue(1'b0, 32'h1C, 3'd2, 32'h0);
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    issue(1'b0, 32'h1F, 3'd5, 32'h0);

    // Wrap from the last word to word 0.
    issue(1'b1, 32'hFFE, 3'd2, 32'h11223344);
    issue(1'b0, 32'hFFE, 3'd2, 32'h0);
    issue(1'b0, 32'hFFC, 3'd2, 32'h0);
    issue(1'b0, 32'h0, 3'd2, 32'h0);

    // Illegal controls leave the array alone.
    issue(1'b1, 32'h10, 3'd4, 32'h55555555);
    issue(1'b0, 32'h10, 3'd3, 32'h0);
    issue(1'b1, 32'h12, 3'd5, 32'hAAAAAAAA);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    drain();

    // Backpressure with a competing request held on the input.
    rr_mode = 2;
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", 32'(resp_valid), 32'd1);
    e = model_access(1'b0, 32'h1C, 3'd2, 32'h0);
    drive_req(1'b0, 32'h1C, 3'd2, 32'h0);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_no_accept", 32'(req_ready), 32'd0);
    end
    rr_mode = 1;
    wait_accept(edge_n);
    check("bp_accept_edge", 32'(edge_n), 32'(last_hs_edge + 1));
    e.acc_edge = edge_n;
    if (edge_n >= 0) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
    rr_mode = 0;

    // Reset during the second access of a split store.
    drive_req(1'b1, 32'h2E, 3'd2, 32'h11223344);
    wait_accept(edge_n);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    mem_model[32'h2E] = 8'h44;
    mem_model[32'h2F] = 8'h33;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 32'h2C, 3'd2, 32'h0);
    issue(1'b0, 32'h30, 3'd2, 32'h0);

    // Random traffic over the initialised words, upper address bits scrambled.
    for (int i = 0; i < 150; i++) begin
      hi   = $urandom;
      widx = ($urandom % 2 == 0) ? 10'($urandom_range(0, 14)) : 10'($urandom_range(1016, 1023));
      off  = 2'($urandom % 4);
      c    = ctrl_tab[$urandom % 10];
      we   = 1'($urandom % 2);
      issue(we, {hi[31:12], widx, off}, c, $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
